// File: rtl/score_text_renderer_if.sv
// Pixel-side bus between the score text renderer, the character RAM and the font ROM.
// master: scan generator plus memories; slave: the renderer.
interface score_text_renderer_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pixel_valid;
  logic        frame_start;
  logic        blink;
  logic [7:0]  read_address;
  logic [7:0]  data_Out;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        text_on;

  modport master (
    output DrawX, DrawY, pixel_valid, frame_start, blink, data_Out, font_data,
    input  read_address, font_addr, text_on
  );

  modport slave (
    input  DrawX, DrawY, pixel_valid, frame_start, blink, data_Out, font_data,
    output read_address, font_addr, text_on
  );
endinterface

// File: rtl/score_text_renderer.sv
// Score/status text renderer: scan position -> char RAM read -> font ROM lookup -> text_on.
// Free-running 3-stage pipeline, plus a frame-based blink timer for a status address range.
module score_text_renderer #(
  parameter int unsigned TEXT_X0      = 0,
  parameter int unsigned TEXT_Y0      = 448,
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned BLINK_LO     = 113,
  parameter int unsigned BLINK_HI     = 121,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  score_text_renderer_if.slave  bus
);

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // 11-bit bounds so a region ending at 1024 still compares correctly
  localparam logic [10:0] XLo = 11'(TEXT_X0);
  localparam logic [10:0] XHi = 11'(TEXT_X0 + 8 * COLS);
  localparam logic [10:0] YLo = 11'(TEXT_Y0);
  localparam logic [10:0] YHi = 11'(TEXT_Y0 + 16 * ROWS);
  localparam logic [9:0]  X0  = 10'(TEXT_X0);
  localparam logic [9:0]  Y0  = 10'(TEXT_Y0);
  localparam logic [7:0]  BLo = 8'(BLINK_LO);
  localparam logic [7:0]  BHi = 8'(BLINK_HI);
  localparam logic [7:0]  Cols8 = 8'(COLS);
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

  // Stage 0 outputs
  logic [7:0]  read_address_q, read_address_d;
  logic        v1_q, v1_d;
  logic [3:0]  glyph_row1_q, glyph_row1_d;
  logic [2:0]  bit_sel1_q, bit_sel1_d;
  logic        brange1_q, brange1_d;
  // Stage 1 outputs
  logic [10:0] font_addr_q, font_addr_d;
  logic        v2_q, v2_d;
  logic [2:0]  bit_sel2_q, bit_sel2_d;
  logic        blank2_q, blank2_d;
  // Stage 2 output
  logic        text_on_q, text_on_d;
  // Blink timer
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  logic [9:0] dx, dy;
  logic [7:0] addr;
  logic       in_region;

  // Scan position to character address and region test
  always_comb begin
    dx = bus.DrawX - X0;
    dy = bus.DrawY - Y0;
    // mod-256 arithmetic matches truncating the full product-sum to 8 bits
    addr = 8'(dy[9:4]) * Cols8 + 8'(dx[9:3]);
    in_region = bus.pixel_valid &&
                ({1'b0, bus.DrawX} >= XLo) && ({1'b0, bus.DrawX} < XHi) &&
                ({1'b0, bus.DrawY} >= YLo) && ({1'b0, bus.DrawY} < YHi);
  end

  // Pipeline next-state: address issue, font lookup, pixel select
  always_comb begin
    read_address_d = in_region ? addr : 8'd0;
    v1_d           = in_region;
    glyph_row1_d   = dy[3:0];
    bit_sel1_d     = dx[2:0];
    brange1_d      = (addr >= BLo) && (addr <= BHi);

    font_addr_d = {bus.data_Out[6:0], glyph_row1_q};
    // Null char and high-bit chars render blank; blink phase is sampled here
    blank2_d    = (bus.data_Out == 8'd0) || bus.data_Out[7] ||
                  (brange1_q && bus.blink && blink_phase_q);
    v2_d        = v1_q;
    bit_sel2_d  = bit_sel1_q;

    text_on_d = v2_q && !blank2_q && bus.font_data[3'd7 - bit_sel2_q];
  end

  // Blink timer next-state; blink low clears and wins over frame_start
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!bus.blink) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt_q == CntLast) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_q <= '0;
      v1_q           <= 1'b0;
      glyph_row1_q   <= '0;
      bit_sel1_q     <= '0;
      brange1_q      <= 1'b0;
      font_addr_q    <= '0;
      v2_q           <= 1'b0;
      bit_sel2_q     <= '0;
      blank2_q       <= 1'b0;
      text_on_q      <= 1'b0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
    end else begin
      read_address_q <= read_address_d;
      v1_q           <= v1_d;
      glyph_row1_q   <= glyph_row1_d;
      bit_sel1_q     <= bit_sel1_d;
      brange1_q      <= brange1_d;
      font_addr_q    <= font_addr_d;
      v2_q           <= v2_d;
      bit_sel2_q     <= bit_sel2_d;
      blank2_q       <= blank2_d;
      text_on_q      <= text_on_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.font_addr    = font_addr_q;
  assign bus.text_on      = text_on_q;

endmodule

// File: tb/tb_score_text_renderer.sv
// Directed bench for score_text_renderer with asynchronous-read RAM/ROM models.
module tb_score_text_renderer;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  logic [7:0] ram [256];
  logic [7:0] rom [2048];

  score_text_renderer_if bus ();

  score_text_renderer #(
    .BLINK_FRAMES (2)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  assign bus.data_Out  = ram[bus.read_address];
  assign bus.font_data = rom[bus.font_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweep 8 pixels starting at (x0,y); bits[7-j] is the expected text_on of pixel j
  task automatic run_row(input logic [9:0] x0, input logic [9:0] y, input logic valid,
                         input logic [7:0] ra0, input logic [7:0] bits, input string tag);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        bus.DrawX       = x0 + 10'(i);
        bus.DrawY       = y;
        bus.pixel_valid = valid;
      end else begin
        bus.pixel_valid = 1'b0;
      end
      tick();
      if (i == 0) chk({tag, "_ra"}, {24'd0, bus.read_address}, {24'd0, ra0});
      if (i < 2) chk({tag, "_idle"}, {31'd0, bus.text_on}, 32'd0);
      else if (i < 10) chk(tag, {31'd0, bus.text_on}, {31'd0, bits[7-(i-2)]});
    end
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    ram[0]   = 8'h53;  rom[11'h533] = 8'h3C;
    rom[11'h53F] = 8'hFF;  rom[11'h530] = 8'hFF;  // rows never reached legally
    ram[1]   = 8'h00;  rom[11'h003] = 8'hFF;
    ram[2]   = 8'h85;  rom[11'h053] = 8'hFF;
    ram[112] = 8'h41;  ram[113] = 8'h41;  rom[11'h413] = 8'hFF;

    bus.DrawX = '0;  bus.DrawY = '0;  bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;  bus.blink = 1'b0;

    // Reset state
    Reset_n = 1'b0;
    #3;
    chk("rst_ra", {24'd0, bus.read_address}, 32'd0);
    chk("rst_fa", {21'd0, bus.font_addr}, 32'd0);
    chk("rst_ton", {31'd0, bus.text_on}, 32'd0);
    #4 Reset_n = 1'b1;
    tick();

    // Address mapping
    bus.DrawX = 10'd200; bus.DrawY = 10'd448; bus.pixel_valid = 1'b1;
    tick();
    chk("addr_25", {24'd0, bus.read_address}, 32'd25);
    bus.DrawX = 10'd0; bus.DrawY = 10'd464;
    tick();
    chk("addr_80", {24'd0, bus.read_address}, 32'd80);
    bus.DrawX = 10'd639; bus.DrawY = 10'd479;
    tick();
    chk("addr_159", {24'd0, bus.read_address}, 32'd159);
    bus.pixel_valid = 1'b0;
    tick(); tick(); tick();

    // Glyph render, with font_addr check two cycles after the first pixel
    bus.DrawX = 10'd0; bus.DrawY = 10'd451; bus.pixel_valid = 1'b1;
    tick();
    bus.DrawX = 10'd1;
    tick();
    chk("font_addr", {21'd0, bus.font_addr}, 32'h533);
    bus.pixel_valid = 1'b0;
    tick(); tick(); tick();
    run_row(10'd0, 10'd451, 1'b1, 8'd0, 8'h3C, "glyph");

    // Blanking and pixel_valid gating
    run_row(10'd8,  10'd451, 1'b1, 8'd1, 8'h00, "blank_null");
    run_row(10'd16, 10'd451, 1'b1, 8'd2, 8'h00, "blank_hi");
    run_row(10'd0,  10'd451, 1'b0, 8'd0, 8'h00, "invalid");

    // Region bounds
    run_row(10'd0,   10'd447, 1'b1, 8'd0, 8'h00, "y447");
    run_row(10'd0,   10'd480, 1'b1, 8'd0, 8'h00, "y480");
    run_row(10'd640, 10'd451, 1'b1, 8'd0, 8'h00, "x640");

    // Blink with two frames per half-period
    bus.blink = 1'b1;
    tick();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'hFF, "blink_f0");
    run_row(10'd256, 10'd467, 1'b1, 8'd112, 8'hFF, "nblink_f0");
    pulse_frame();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'hFF, "blink_f1");
    pulse_frame();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'h00, "blink_f2");
    run_row(10'd256, 10'd467, 1'b1, 8'd112, 8'hFF, "nblink_f2");
    pulse_frame();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'h00, "blink_f3");
    pulse_frame();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'hFF, "blink_f4");
    pulse_frame();
    pulse_frame();
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'h00, "blink_f6");
    bus.blink = 1'b0;
    tick();
    chk("drop_cnt", 32'(dut.frame_cnt_q), 32'd0);
    chk("drop_phase", {31'd0, dut.blink_phase_q}, 32'd0);
    run_row(10'd264, 10'd467, 1'b1, 8'd113, 8'hFF, "blink_off");
    bus.blink = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("rise_cnt", 32'(dut.frame_cnt_q), 32'd1);
    chk("rise_phase", {31'd0, dut.blink_phase_q}, 32'd0);
    bus.blink = 1'b0;
    tick();

    // Reset in the middle of a lit glyph
    for (int i = 0; i < 5; i++) begin
      bus.DrawX = 10'(i); bus.DrawY = 10'd451; bus.pixel_valid = 1'b1;
      tick();
    end
    chk("pre_rst_lit", {31'd0, bus.text_on}, 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_ton", {31'd0, bus.text_on}, 32'd0);
    chk("mid_rst_ra", {24'd0, bus.read_address}, 32'd0);
    chk("mid_rst_fa", {21'd0, bus.font_addr}, 32'd0);
    #1 Reset_n = 1'b1;
    run_row(10'd0, 10'd451, 1'b1, 8'd0, 8'h3C, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
